key_debounce_n: RTL

Parametrised multi-key debouncer and event generator for front-panel push-buttons. It samples `KEY_NUM` raw key inputs, synchronises and debounces each one independently on a shared 1 ms tick, and produces a stable pressed level plus single-cycle press, release, long-press and optional auto-repeat pulses per key. It sits between the board key pins and the UI/LED control logic, and replaces the fixed 4-key, one-hot, first-key-wins debouncer.

---
 rtl/key_debounce_n.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/key_debounce_n.sv
// key_debounce_n: per-key debouncer with press/release/long/repeat pulses.
// Define KEY_DEBOUNCE_REPEAT_EN to build the auto-repeat counters.
module key_debounce_n #(
    parameter int KEY_NUM     = 4,
    parameter int CLK_FREQ    = 50_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000,
    parameter int REPEAT_MS   = 200,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic [KEY_NUM-1:0] key_in,
    output logic [KEY_NUM-1:0] key_level,
    output logic [KEY_NUM-1:0] key_press,
    output logic [KEY_NUM-1:0] key_release,
    output logic [KEY_NUM-1:0] key_long,
    output logic [KEY_NUM-1:0] key_repeat,
    output logic               key_any
);

    localparam int TICK_DIV = CLK_FREQ / 1000;
    localparam int TC_W     = $clog2(TICK_DIV);
    localparam int DB_W     = $clog2(DEBOUNCE_MS + 1);
    localparam int HD_W     = $clog2(LONG_MS + 1);

    localparam logic [TC_W-1:0] TC_LAST = TC_W'(TICK_DIV - 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_MS - 1);
    localparam logic [HD_W-1:0] LG_MAX  = HD_W'(LONG_MS);
    localparam logic [HD_W-1:0] LG_LAST = HD_W'(LONG_MS - 1);
    localparam logic            IDLE_LVL = (ACTIVE_LOW != 0);

`ifdef KEY_DEBOUNCE_REPEAT_EN
    localparam int RP_W = $clog2(REPEAT_MS + 1);
    localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_MS - 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS_DB,
        S_HELD,
        S_REL_DB
    } state_t;

    logic [TC_W-1:0]    r_tick_cnt;
    logic               w_tick;
    logic [KEY_NUM-1:0] r_sync1;
    logic [KEY_NUM-1:0] r_sync2;
    logic [KEY_NUM-1:0] w_raw;
    logic [KEY_NUM-1:0] w_level_nxt;
    logic               r_any;

    assign w_tick = (r_tick_cnt == TC_LAST);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    // Synchronisers reset to the released pin level so reset never fakes a press.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sync1 <= {KEY_NUM{IDLE_LVL}};
            r_sync2 <= {KEY_NUM{IDLE_LVL}};
        end else begin
            r_sync1 <= key_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_raw = IDLE_LVL ? ~r_sync2 : r_sync2;

    for (genvar k = 0; k < KEY_NUM; k++) begin : g_key
        state_t          r_state;
        state_t          w_state_n;
        logic [DB_W-1:0] r_db;
        logic [DB_W-1:0] w_db_n;
        logic [HD_W-1:0] r_hold;
        logic [HD_W-1:0] w_hold_n;
        logic            r_level;
        logic            w_level_n;
        logic            r_press;
        logic            w_press_n;
        logic            r_rel;
        logic            w_rel_n;
        logic            r_long;
        logic            w_long_n;
`ifdef KEY_DEBOUNCE_REPEAT_EN
        logic [RP_W-1:0] r_rep;
        logic [RP_W-1:0] w_rep_n;
        logic            r_rpt;
        logic            w_rpt_n;
`endif

        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                r_state <= S_IDLE;
                r_db    <= '0;
                r_hold  <= '0;
                r_level <= 1'b0;
                r_press <= 1'b0;
                r_rel   <= 1'b0;
                r_long  <= 1'b0;
`ifdef KEY_DEBOUNCE_REPEAT_EN
                r_rep   <= '0;
                r_rpt   <= 1'b0;
`endif
            end else begin
                r_state <= w_state_n;
                r_db    <= w_db_n;
                r_hold  <= w_hold_n;
                r_level <= w_level_n;
                r_press <= w_press_n;
                r_rel   <= w_rel_n;
                r_long  <= w_long_n;
`ifdef KEY_DEBOUNCE_REPEAT_EN
                r_rep   <= w_rep_n;
                r_rpt   <= w_rpt_n;
`endif
            end
        end

        always_comb begin
            w_state_n = r_state;
            w_db_n    = r_db;
            w_hold_n  = r_hold;
            w_level_n = r_level;
            w_press_n = 1'b0;
            w_rel_n   = 1'b0;
            w_long_n  = 1'b0;
`ifdef KEY_DEBOUNCE_REPEAT_EN
            w_rep_n   = r_rep;
            w_rpt_n   = 1'b0;
`endif
            // A raw change wins over a coincident tick.
            unique case (r_state)
                S_IDLE: begin
                    if (w_raw[k]) begin
                        w_state_n = S_PRESS_DB;
                        w_db_n    = '0;
                    end
                end
                S_PRESS_DB: begin
                    if (!w_raw[k]) begin
                        w_state_n = S_IDLE;
                    end else if (w_tick) begin
                        w_db_n = r_db + 1'b1;
                        if (r_db == DB_LAST) begin
                            w_state_n = S_HELD;
                            w_level_n = 1'b1;
                            w_press_n = 1'b1;
                            w_hold_n  = '0;
`ifdef KEY_DEBOUNCE_REPEAT_EN
                            w_rep_n   = '0;
`endif
                        end
                    end
                end
                S_HELD: begin
                    if (!w_raw[k]) begin
                        w_state_n = S_REL_DB;
                        w_db_n    = '0;
                    end else if (w_tick) begin
                        if (r_hold != LG_MAX) begin
                            w_hold_n = r_hold + 1'b1;
                            w_long_n = (r_hold == LG_LAST);
                        end
`ifdef KEY_DEBOUNCE_REPEAT_EN
                        else if (r_rep == RP_LAST) begin
                            w_rep_n = '0;
                            w_rpt_n = 1'b1;
                        end else begin
                            w_rep_n = r_rep + 1'b1;
                        end
`endif
                    end
                end
                S_REL_DB: begin
                    if (w_raw[k]) begin
                        w_state_n = S_HELD;
                    end else if (w_tick) begin
                        w_db_n = r_db + 1'b1;
                        if (r_db == DB_LAST) begin
                            w_state_n = S_IDLE;
                            w_level_n = 1'b0;
                            w_rel_n   = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_n = S_IDLE;
                end
            endcase
        end

        assign w_level_nxt[k] = w_level_n;
        assign key_level[k]   = r_level;
        assign key_press[k]   = r_press;
        assign key_release[k] = r_rel;
        assign key_long[k]    = r_long;
`ifdef KEY_DEBOUNCE_REPEAT_EN
        assign key_repeat[k]  = r_rpt;
`endif
    end

`ifndef KEY_DEBOUNCE_REPEAT_EN
    logic w_unused_rep;
    assign w_unused_rep = (REPEAT_MS > 0);
    assign key_repeat   = '0;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_any <= 1'b0;
        end else begin
            r_any <= |w_level_nxt;
        end
    end

    assign key_any = r_any;

endmodule
